writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/cpu_pkg.sv | 17 +
 rtl/wb_fifo.sv | 78 +++++++
 rtl/writeback_unit.sv | 88 ++++++++
 tb/tb_writeback_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- constants and types shared by the CPU pipeline blocks.
//   XLEN        register data width
//   REG_ADDR_W  register-file address width
//   NUM_REGS    number of architectural registers
//   wb_entry_t  one pending register write: {rd, data}
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- pending write-back queue with two push slots and one pop.
//   clk, reset_n     clock (rising edge), asynchronous active-low reset
//   push_a, data_a   first push slot (enqueued first)
//   push_b, data_b   second push slot; takes the first free position when
//                    push_a is low
//   pop              remove the head entry (ignored when empty)
//   head             oldest entry, combinational
//   count            number of queued entries, 0..DEPTH
// The caller guarantees it never pushes more than the free space allows.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = $bits(wb_entry_t),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             push_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_next_slot;
  logic             slot0_we;
  logic             slot1_we;
  logic [WIDTH-1:0] slot0_data;
  logic [1:0]       n_push;
  logic             do_pop;

  // Pack the pushes so the first valid one always lands at wr_ptr.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    slot0_we   = push_a | push_b;
    slot0_data = data_b;
    if (push_a) slot0_data = data_a;
    slot1_we   = push_a & push_b;
    n_push     = {1'b0, push_a} + {1'b0, push_b};
  end

  // Pointer arithmetic is PTR_W bits wide, so DEPTH being a power of two
  // makes every increment wrap for free, including the second slot.
  assign wr_ptr_next_slot = wr_ptr + PTR_W'(1);
  assign do_pop           = pop && (count != '0);

  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (slot0_we) mem[wr_ptr] <= slot0_data;
    if (slot1_we) mem[wr_ptr_next_slot] <= data_b;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count + CNT_W'(n_push) - CNT_W'(do_pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit -- merges load and ALU results into a single register-file
// write port through a small queue, and tracks pending writes per register.
//   clk, reset_n                      clock, asynchronous active-low reset
//   mem_valid/ready, mem_rd, mem_data load result producer handshake
//   alu_valid/ready, alu_rd, alu_data ALU result producer handshake
//   issue_valid, issue_rd             decode issued a register-writing instr
//   regwrite, write_reg, write_data   register-file write port (one per cycle)
//   busy                              per-register pending-write scoreboard
module writeback_unit #(
  parameter int DEPTH = 4,
  parameter int XLEN  = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            regwrite,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     busy
);

  import cpu_pkg::*;

  localparam int ENTRY_W = REG_ADDR_W + XLEN;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   free;
  logic [ENTRY_W-1:0] head;
  logic               mem_push;
  logic               alu_push;
  logic [31:0]        busy_next;

  // The head leaves on this edge whenever anything is queued, so one
  // extra slot is available to the producers.
  assign free      = CNT_W'(DEPTH) - count + CNT_W'(count != '0);
  assign mem_ready = (free >= CNT_W'(1));
  assign alu_ready = (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !mem_valid);

  // Results for x0 complete their handshake but are dropped here.
  assign mem_push = mem_valid && mem_ready && (mem_rd != '0);
  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_a  (mem_push),
    .data_a  ({mem_rd, mem_data}),
    .push_b  (alu_push),
    .data_b  ({alu_rd, alu_data}),
    .pop     (regwrite),
    .head    (head),
    .count   (count)
  );

  // Outputs are forced to zero when empty so an unwritten queue slot is
  // never visible on the write port.
  assign regwrite   = (count != '0);
  assign write_reg  = regwrite ? head[ENTRY_W-1 -: REG_ADDR_W] : '0;
  assign write_data = regwrite ? head[XLEN-1:0] : '0;

  // Set is applied after clear so an issue to the register being written
  // back on the same edge keeps it busy.
  always_comb begin
    busy_next = busy;
    if (regwrite) busy_next[write_reg] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_next;
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] busy;

  writeback_unit #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .regwrite    (regwrite),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of pending writes and a busy bit vector.
  wb_entry_t   model_q[$];
  logic [31:0] busy_m = '0;
  // Producer stimulus: items waiting to be offered, front is held until taken.
  wb_entry_t   mem_src[$];
  wb_entry_t   alu_src[$];
  // Writes observed on the DUT write port.
  wb_entry_t   obs[$];
  bit          saw_alu_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wb_entry_t mk(input logic [4:0] rd, input logic [31:0] data);
    wb_entry_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

  // One clock cycle: called just after a falling edge.
  task automatic cycle();
    int          free;
    bit          exp_mr, exp_ar, hs_m, hs_a;
    logic [31:0] nb;
    mem_valid = (mem_src.size() != 0);
    mem_rd    = mem_valid ? mem_src[0].rd : 5'd0;
    mem_data  = mem_valid ? mem_src[0].data : 32'd0;
    alu_valid = (alu_src.size() != 0);
    alu_rd    = alu_valid ? alu_src[0].rd : 5'd0;
    alu_data  = alu_valid ? alu_src[0].data : 32'd0;
    #1;
    free   = DEPTH - model_q.size() + ((model_q.size() > 0) ? 1 : 0);
    exp_mr = (free >= 1);
    exp_ar = (free >= 2) || ((free >= 1) && !mem_valid);
    check("mem_ready", mem_ready, exp_mr);
    check("alu_ready", alu_ready, exp_ar);
    check("regwrite", regwrite, model_q.size() != 0);
    check("write_reg", write_reg, (model_q.size() != 0) ? model_q[0].rd : 5'd0);
    check("write_data", write_data, (model_q.size() != 0) ? model_q[0].data : 32'd0);
    check("busy", busy, busy_m);
    if (alu_valid && !alu_ready) saw_alu_stall = 1'b1;
    if (regwrite) obs.push_back(mk(write_reg, write_data));
    hs_m = mem_valid && exp_mr;
    hs_a = alu_valid && exp_ar;
    nb = busy_m;
    if (model_q.size() != 0) begin
      nb[model_q[0].rd] = 1'b0;
      void'(model_q.pop_front());
    end
    if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
    busy_m = nb;
    if (hs_m && mem_rd != 0) model_q.push_back(mk(mem_rd, mem_data));
    if (hs_a && alu_rd != 0) model_q.push_back(mk(alu_rd, alu_data));
    @(posedge clk);
    if (hs_m) void'(mem_src.pop_front());
    if (hs_a) void'(alu_src.pop_front());
    @(negedge clk);
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
  endtask

  task automatic drain();
    int n = 0;
    while ((model_q.size() != 0 || mem_src.size() != 0 || alu_src.size() != 0) && n < 40) begin
      cycle();
      n++;
    end
    check("drain_timeout", (n < 40), 1);
    cycle();
  endtask

  task automatic check_order(input string name, input wb_entry_t exp[$]);
    check({name, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      check(name, obs[i], exp[i]);
  endtask

  initial begin
    wb_entry_t exp[$];

    // Reset state, with producers offering during reset.
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h1234;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h5678;
    @(negedge clk); @(negedge clk); #1;
    check("rst_regwrite", regwrite, 0);
    check("rst_write_reg", write_reg, 0);
    check("rst_write_data", write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_alu_ready", alu_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    // Single ALU result to r5 after an issue to r5.
    issue_valid = 1'b1; issue_rd = 5'd5;
    cycle();
    alu_src.push_back(mk(5'd5, 32'hDEADBEEF));
    cycle();
    check("r5_regwrite", regwrite, 1);
    check("r5_write_reg", write_reg, 5);
    check("r5_write_data", write_data, 32'hDEADBEEF);
    check("r5_busy_set", busy[5], 1);
    cycle();
    check("r5_busy_clear", busy[5], 0);
    check("r5_done", regwrite, 0);
    drain();

    // Both producers streaming: interleaved order, ALU stalls when free < 2.
    obs.delete(); exp.delete(); saw_alu_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_src.push_back(mk(5'(1 + i), 32'h1000_0000 + i));
      alu_src.push_back(mk(5'(10 + i), 32'h2000_0000 + i));
      exp.push_back(mk(5'(1 + i), 32'h1000_0000 + i));
      exp.push_back(mk(5'(10 + i), 32'h2000_0000 + i));
    end
    drain();
    check("stream_alu_stall", saw_alu_stall, 1);
    check_order("stream_order", exp);

    // ALU result for x0 while full: blocked until alu_ready, never written.
    obs.delete(); saw_alu_stall = 1'b0;
    for (int i = 0; i < 6; i++) mem_src.push_back(mk(5'(20 + i), 32'h3000_0000 + i));
    for (int i = 0; i < 3; i++) alu_src.push_back(mk(5'(26 + i), 32'h3100_0000 + i));
    alu_src.push_back(mk(5'd0, 32'hBAD0BAD0));
    drain();
    check("x0_stall_seen", saw_alu_stall, 1);
    check("x0_write_total", obs.size(), 9);
    for (int i = 0; i < obs.size(); i++) check("x0_not_written", obs[i].rd != 0, 1);

    // Issue to r7 on the same edge r7 is written back: set wins.
    issue_valid = 1'b1; issue_rd = 5'd7;
    alu_src.push_back(mk(5'd7, 32'h0000_0077));
    cycle();
    check("r7_on_port", write_reg, 7);
    issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    check("r7_busy_kept", busy[7], 1);
    drain();

    // Reset mid-cycle with three entries queued.
    issue_valid = 1'b1; issue_rd = 5'd12;
    for (int i = 0; i < 2; i++) begin
      mem_src.push_back(mk(5'(13 + i), 32'h4000_0000 + i));
      alu_src.push_back(mk(5'(15 + i), 32'h4100_0000 + i));
    end
    cycle();
    cycle();
    check("pre_rst_queued", model_q.size(), 3);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_regwrite", regwrite, 0);
    check("mid_rst_write_reg", write_reg, 0);
    check("mid_rst_write_data", write_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_ready", mem_ready, 1);
    check("mid_rst_alu_ready", alu_ready, 1);
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9999;
    @(posedge clk); @(negedge clk); #1;
    check("held_rst_regwrite", regwrite, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_q.delete(); mem_src.delete(); alu_src.delete(); busy_m = '0;
    obs.delete();
    cycle();
    cycle();
    check("post_rst_no_write", obs.size(), 0);

    // Pointer wrap: three singles move the write pointer to DEPTH-1,
    // then dual pushes straddle the wrap.
    for (int i = 0; i < DEPTH - 1; i++) mem_src.push_back(mk(5'(1 + i), 32'h30 + i));
    drain();
    obs.delete(); exp.delete();
    for (int i = 0; i < 4; i++) begin
      mem_src.push_back(mk(5'(16 + i), 32'h5000_0000 + i));
      alu_src.push_back(mk(5'(24 + i), 32'h6000_0000 + i));
      exp.push_back(mk(5'(16 + i), 32'h5000_0000 + i));
      exp.push_back(mk(5'(24 + i), 32'h6000_0000 + i));
    end
    drain();
    check_order("wrap_order", exp);

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [4:0] r;
      if (mem_src.size() == 0 && $urandom_range(0, 2) != 0)
        mem_src.push_back(mk(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom));
      if (alu_src.size() == 0 && $urandom_range(0, 2) != 0)
        alu_src.push_back(mk(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom));
      r = 5'($urandom);
      if ($urandom_range(0, 1) == 1 && !busy_m[r]) begin
        issue_valid = 1'b1;
        issue_rd    = r;
      end
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
